multadd_pipe: RTL and testbench

Signed multiply-accumulate primitive computing p = a*b + c with a registered, parameterizable-latency output. It serves as the DSP-style arithmetic leaf inside motion-vector scaling (distScaleFactor and scaled-MV computation). Operand widths are parameters so one block covers every multiply-add in the datapath. Callers feed unsigned values by prepending a 0 MSB.

---
 rtl/multadd_pipe.sv | 83 ++++++++
 tb/tb_multadd_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multadd_pipe.sv
// Signed multiply-add leaf p = a*b + c with a 1..4 stage registered output.
// Full-precision product and sum; the result is sign-extended or wrapped to PW bits.
module multadd_pipe #(
    parameter int AW      = 9,
    parameter int BW      = 18,
    parameter int CW      = 7,
    parameter int PW      = 26,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    input  logic signed [CW-1:0] c,
    output logic signed [PW-1:0] p
);

    localparam int PROD_W = AW + BW;
    localparam int SUM_W  = ((PROD_W > CW) ? PROD_W : CW) + 1;

    if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
        $error("multadd_pipe: LATENCY must be within 1..4");
    end
    if ((AW < 2) || (BW < 2) || (CW < 2) || (PW < 2)) begin : g_bad_width
        $error("multadd_pipe: every operand and result width must be at least 2");
    end

    // Signed size cast: sign-extends when PW > SUM_W, keeps the PW LSBs otherwise.
    function automatic logic signed [PW-1:0] fit_pw(input logic signed [SUM_W-1:0] s);
        return PW'(s);
    endfunction

    logic signed [PROD_W-1:0] prod_d;

    assign prod_d = PROD_W'(a) * PROD_W'(b);

    if (LATENCY == 1) begin : g_lat1
        logic signed [SUM_W-1:0] sum_d;
        logic signed [PW-1:0]    p_q;

        assign sum_d = SUM_W'(prod_d) + SUM_W'(c);

        // Single output register holding the full multiply-add result.
        always_ff @(posedge clk) begin
            if (rst) begin
                p_q <= {PW{1'b0}};
            end else begin
                p_q <= fit_pw(sum_d);
            end
        end

        assign p = p_q;
    end else begin : g_latn
        logic signed [PROD_W-1:0] prod_q;
        logic signed [CW-1:0]     c_q;
        logic signed [SUM_W-1:0]  sum_d;
        logic signed [PW-1:0]     out_q [LATENCY-1];

        // c is delayed alongside the product so both meet at the adder.
        assign sum_d = SUM_W'(prod_q) + SUM_W'(c_q);

        // Product stage, then adder stage, then the remaining output delay stages.
        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= {PROD_W{1'b0}};
                c_q    <= {CW{1'b0}};
                for (int i = 0; i < LATENCY - 1; i++) begin
                    out_q[i] <= {PW{1'b0}};
                end
            end else begin
                prod_q   <= prod_d;
                c_q      <= c;
                out_q[0] <= fit_pw(sum_d);
                for (int i = 1; i < LATENCY - 1; i++) begin
                    out_q[i] <= out_q[i-1];
                end
            end
        end

        assign p = out_q[LATENCY-2];
    end

endmodule

// File: tb/tb_multadd_pipe.sv
// Directed bench for multadd_pipe: default, wide, wrapping and 3-stage instances
// checked against hand-computed results, including streaming and mid-stream reset.
module tb_multadd_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic signed [8:0]  a0, a3;
    logic signed [17:0] b0, b3;
    logic signed [6:0]  c0, c3;
    logic signed [25:0] p0, p3;

    logic signed [12:0] a1;
    logic signed [14:0] b1;
    logic signed [7:0]  c1;
    logic signed [26:0] p1;

    logic signed [5:0]  a2, b2;
    logic signed [1:0]  c2;
    logic signed [7:0]  p2;

    multadd_pipe u_def (.clk(clk), .rst(rst), .a(a0), .b(b0), .c(c0), .p(p0));

    multadd_pipe #(.AW(13), .BW(15), .CW(8), .PW(27), .LATENCY(1))
        u_big (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .p(p1));

    multadd_pipe #(.AW(6), .BW(6), .CW(2), .PW(8), .LATENCY(1))
        u_wrap (.clk(clk), .rst(rst), .a(a2), .b(b2), .c(c2), .p(p2));

    multadd_pipe #(.AW(9), .BW(18), .CW(7), .PW(26), .LATENCY(3))
        u_l3 (.clk(clk), .rst(rst), .a(a3), .b(b3), .c(c3), .p(p3));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        longint a;
        longint b;
        longint c;
        longint e;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_l3(input int j);
        if (j < 6) begin
            a3 = 9'(vecs[j].a);
            b3 = 18'(vecs[j].b);
            c3 = 7'(vecs[j].c);
        end else begin
            a3 = 9'sd0;
            b3 = 18'sd0;
            c3 = 7'sd0;
        end
    endtask

    initial begin
        vecs[0] = '{a: 3,    b: 7,       c: 1,   e: 22};
        vecs[1] = '{a: -5,   b: 100,     c: -2,  e: -502};
        vecs[2] = '{a: 255,  b: 131071,  c: 63,  e: 33423168};
        vecs[3] = '{a: -256, b: -131072, c: -64, e: 33554368};
        vecs[4] = '{a: -1,   b: -1,      c: -64, e: -63};
        vecs[5] = '{a: 100,  b: -1000,   c: 10,  e: -99990};

        a0 = 9'sd7;  b0 = 18'sd9;  c0 = 7'sd3;
        a1 = 13'sd5; b1 = 15'sd5;  c1 = 8'sd5;
        a2 = 6'sd3;  b2 = 6'sd3;   c2 = 2'sd1;
        a3 = 9'sd2;  b3 = 18'sd2;  c3 = 7'sd2;

        // Reset clears every instance regardless of operands.
        tick();
        tick();
        check("reset_p_def",  p0, 0);
        check("reset_p_big",  p1, 0);
        check("reset_p_wrap", p2, 0);
        check("reset_p_l3",   p3, 0);

        rst = 1'b0;
        a0 = 9'sd4;     b0 = 18'sd4096;  c0 = 7'sd32;
        a1 = 13'sd4095; b1 = 15'sd16383; c1 = 8'sd127;
        a2 = 6'sd16;    b2 = 6'sd16;     c2 = 2'sd1;
        a3 = 9'sd0;     b3 = 18'sd0;     c3 = 7'sd0;
        tick();
        check("def_basic",       p0, 16416);
        check("def_basic_slice", p0[24:6], 256);
        check("big_max_unsigned", p1, 67088512);
        check("wrap_pw8",        p2, 1);
        check("l3_first_zero",   p3, 0);

        tick();
        check("def_held_stable", p0, 16416);

        a0 = -9'sd3; b0 = 18'sd5; c0 = -7'sd1;
        tick();
        check("def_signed_small", p0, -16);

        a0 = -9'sd256; b0 = -18'sd131072; c0 = -7'sd64;
        tick();
        check("def_signed_extreme", p0, 33554368);

        // Mid-operation reset on the single-stage instance.
        a0 = 9'sd10; b0 = 18'sd10; c0 = 7'sd5;
        rst = 1'b1;
        tick();
        check("def_reset_flush", p0, 0);
        rst = 1'b0;
        tick();
        check("def_after_reset", p0, 105);

        // Streaming: one new operand set per cycle, result 3 edges later.
        for (int j = 0; j < 8; j++) begin
            drive_l3(j);
            tick();
            check($sformatf("l3_stream_%0d", j), p3, (j >= 2) ? vecs[j-2].e : 0);
        end

        // Reset in the middle of a stream flushes everything in flight.
        drive_l3(0);
        tick();
        drive_l3(1);
        tick();
        drive_l3(2);
        tick();
        check("l3_pre_reset", p3, vecs[0].e);
        drive_l3(3);
        rst = 1'b1;
        tick();
        check("l3_reset_flush", p3, 0);
        rst = 1'b0;
        drive_l3(4);
        tick();
        check("l3_post_reset_0", p3, 0);
        drive_l3(5);
        tick();
        check("l3_post_reset_1", p3, 0);
        drive_l3(6);
        tick();
        check("l3_post_reset_v4", p3, vecs[4].e);
        tick();
        check("l3_post_reset_v5", p3, vecs[5].e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
